// File: rtl/scaler_channel_reader.sv
// scaler_channel_reader
// Bus-side reader for the scaler's CHAT (high) / CHBT (low) 14-bit ports.
// It strobes the high word, then the low word, then the high word again.
// If the two high words differ, the scaler carried mid-read. In that case
// the low word and the high word are re-read, up to MAX_RETRY times.
// The result is one coherent 28-bit count with a single-cycle valid pulse.
// Optional feature: define SCALER_READER_MONO_EN to add the mono_err output.
// That output flags a good count that went backwards relative to the last
// good count.
module scaler_channel_reader #(
    parameter int STROBE_CYC = 4,
    parameter int GAP_CYC    = 1,
    parameter int MAX_RETRY  = 3
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        req,
    input  logic [13:0] chat,
    input  logic [13:0] chbt,
    output logic        RCHAT_,
    output logic        RCHBT_,
    output logic        busy,
    output logic        valid,
    output logic [27:0] count,
    output logic [1:0]  retries,
    output logic        fail
`ifdef SCALER_READER_MONO_EN
    ,
    output logic        mono_err
`endif
);

    // One down-counter times both strobe and gap states.
    // It must hold the larger of the two lengths minus one.
    localparam int MAX_CYC = (STROBE_CYC > GAP_CYC) ? STROBE_CYC : GAP_CYC;
    localparam int CW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);
    localparam int RW      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int RW2     = (RW < 2) ? 2 : RW;

    localparam logic [CW-1:0] S_LOAD = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] G_LOAD = CW'(GAP_CYC - 1);
    localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        RDH1,
        GAPA,
        RDL,
        GAPB,
        RDH2,
        CHECK,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   rtry_q, rtry_d;
    logic [13:0]     hi1_q, hi1_d;
    logic [13:0]     lo_q, lo_d;
    logic [13:0]     hi2_q, hi2_d;
    logic [27:0]     count_q, count_d;
    logic [1:0]      retries_q, retries_d;
    logic            fail_q, fail_d;
    logic            rchat_q, rchbt_q, busy_q, valid_q;
    logic            tick;
    logic [RW2-1:0]  rtry_w;
    logic [1:0]      rtry_sat;

    // The 2-bit retries output saturates at 3, whatever MAX_RETRY is.
    assign rtry_w   = RW2'(rtry_q);
    assign rtry_sat = (rtry_w > RW2'(2)) ? 2'd3 : rtry_w[1:0];

    // Last cycle of the current timed state.
    assign tick = (cnt_q == '0);

    // Next-state, sample capture and result formation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = tick ? cnt_q : cnt_q - 1'b1;
        rtry_d    = rtry_q;
        hi1_d     = hi1_q;
        lo_d      = lo_q;
        hi2_d     = hi2_q;
        count_d   = count_q;
        retries_d = retries_q;
        fail_d    = fail_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = RDH1;
                    cnt_d   = S_LOAD;
                    rtry_d  = '0;
                end
            end
            RDH1: begin
                if (tick) begin
                    hi1_d   = chat;
                    state_d = GAPA;
                    cnt_d   = G_LOAD;
                end
            end
            GAPA: begin
                if (tick) begin
                    state_d = RDL;
                    cnt_d   = S_LOAD;
                end
            end
            RDL: begin
                if (tick) begin
                    lo_d    = chbt;
                    state_d = GAPB;
                    cnt_d   = G_LOAD;
                end
            end
            GAPB: begin
                if (tick) begin
                    state_d = RDH2;
                    cnt_d   = S_LOAD;
                end
            end
            RDH2: begin
                if (tick) begin
                    hi2_d   = chat;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (hi2_q == hi1_q) begin
                    state_d   = DONE;
                    count_d   = {hi1_q, lo_q};
                    retries_d = rtry_sat;
                    fail_d    = 1'b0;
                end else if (rtry_q < R_MAX) begin
                    // A carry happened. The newer high word becomes the
                    // reference, and the low/high pair is read again.
                    hi1_d   = hi2_q;
                    rtry_d  = rtry_q + 1'b1;
                    state_d = GAPA;
                    cnt_d   = G_LOAD;
                end else begin
                    state_d   = DONE;
                    count_d   = {hi2_q, lo_q};
                    retries_d = rtry_sat;
                    fail_d    = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, samples, and registered pin outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rtry_q    <= '0;
            hi1_q     <= '0;
            lo_q      <= '0;
            hi2_q     <= '0;
            count_q   <= '0;
            retries_q <= '0;
            fail_q    <= 1'b0;
            rchat_q   <= 1'b1;
            rchbt_q   <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rtry_q    <= rtry_d;
            hi1_q     <= hi1_d;
            lo_q      <= lo_d;
            hi2_q     <= hi2_d;
            count_q   <= count_d;
            retries_q <= retries_d;
            fail_q    <= fail_d;
            rchat_q   <= !((state_d == RDH1) || (state_d == RDH2));
            rchbt_q   <= (state_d != RDL);
            busy_q    <= (state_d != IDLE);
            valid_q   <= (state_d == DONE);
        end
    end

    assign RCHAT_  = rchat_q;
    assign RCHBT_  = rchbt_q;
    assign busy    = busy_q;
    assign valid   = valid_q;
    assign count   = count_q;
    assign retries = retries_q;
    assign fail    = fail_q;

`ifdef SCALER_READER_MONO_EN
    localparam logic [27:0] WRAP_LIM = 28'h010_0000;

    logic [27:0] last_q, last_d;
    logic        mono_q, mono_d;

    // Judge monotonicity on every good (non-fail) result.
    // A wrap from all-ones to a small value is allowed.
    always_comb begin
        last_d = last_q;
        mono_d = mono_q;
        if ((state_q == CHECK) && (state_d == DONE) && !fail_d) begin
            mono_d = (count_d < last_q) &&
                     !((last_q == 28'hFFF_FFFF) && (count_d < WRAP_LIM));
            last_d = count_d;
        end
    end

    // Last-good count and the held error flag.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            last_q <= '0;
            mono_q <= 1'b0;
        end else begin
            last_q <= last_d;
            mono_q <= mono_d;
        end
    end

    assign mono_err = mono_q;
`endif

endmodule

// File: tb/tb_scaler_channel_reader.sv
// Scoreboard bench for scaler_channel_reader (default parameters).
// Stimulus pushes the expected result when a read is issued.
// A negedge monitor pops and compares each valid pulse.
module tb_scaler_channel_reader;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        req = 1'b0;
    logic [13:0] chat = '0;
    logic [13:0] chbt = '0;
    logic        RCHAT_, RCHBT_, busy, valid, fail;
    logic [27:0] count;
    logic [1:0]  retries;
`ifdef SCALER_READER_MONO_EN
    logic        mono_err;
`endif

    scaler_channel_reader dut (
        .clk     (clk),
        .rst_    (rst_),
        .req     (req),
        .chat    (chat),
        .chbt    (chbt),
        .RCHAT_  (RCHAT_),
        .RCHBT_  (RCHBT_),
        .busy    (busy),
        .valid   (valid),
        .count   (count),
        .retries (retries),
        .fail    (fail)
`ifdef SCALER_READER_MONO_EN
        ,
        .mono_err(mono_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [27:0] cnt;
        logic [1:0]  r;
        logic        f;
        logic        m;
        int          vcyc;
    } exp_t;

    exp_t sb[$];

    // Bench-side model of the monotonic check.
    logic [27:0] lg    = '0;
    logic        exp_m = 1'b0;

    int mode   = 0;  // 0 static, 1 single carry, 2 toggle on every high strobe
    int hcount = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at cyc %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [27:0] c, input logic [1:0] r, input logic f, input int vc);
        exp_t e;
        if (!f) begin
            exp_m = (c < lg) && !((lg == 28'hFFFFFFF) && (c < 28'h0100000));
            lg    = c;
        end
        e.cnt  = c;
        e.r    = r;
        e.f    = f;
        e.m    = exp_m;
        e.vcyc = vc;
        sb.push_back(e);
    endtask

    // Monitor: strobe exclusivity every cycle, plus scoreboard compare on valid.
    always @(negedge clk) begin
        if (rst_) begin
            chk("strobe_overlap", {31'd0, (RCHAT_ | RCHBT_)}, 32'd1);
            if (valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid count=%h at cyc %0d", count, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("count",     count,   e.cnt);
                    chk("retries",   retries, e.r);
                    chk("fail",      fail,    e.f);
                    chk("valid_cyc", cyc,     e.vcyc);
                    chk("busy_at_valid", busy, 1'b1);
`ifdef SCALER_READER_MONO_EN
                    chk("mono_err",  mono_err, e.m);
`endif
                end
            end
        end
    end

    // Pulse req for one edge; n = cyc value after the sampling edge.
    task automatic start_read(output int n);
        @(negedge clk);
        req = 1'b1;
        n   = cyc + 1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        int k;
        logic [2:0] expv;

        // Follow the high-word strobe to emulate a scaler carry.
        fork
            forever begin
                @(posedge RCHAT_);
                if (mode == 1) begin
                    if (hcount == 0) begin
                        chat = 14'h0006;
                        chbt = 14'h0000;
                    end
                    hcount++;
                end else if (mode == 2) begin
                    chat = chat + 14'd1;
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_RCHAT_",  RCHAT_,  1'b1);
        chk("rst_RCHBT_",  RCHBT_,  1'b1);
        chk("rst_busy",    busy,    1'b0);
        chk("rst_valid",   valid,   1'b0);
        chk("rst_count",   count,   28'h0);
        chk("rst_retries", retries, 2'd0);
        chk("rst_fail",    fail,    1'b0);
        rst_ = 1'b1;
        repeat (2) @(negedge clk);

        // Clean read, with a cycle-by-cycle strobe/busy pattern check
        chat = 14'h0123;
        chbt = 14'h2ABC;
        start_read(n);
        push(28'h048EABC, 2'd0, 1'b0, n + 15);
        for (int c = 1; c <= 16; c++) begin
            if ((c >= 1 && c <= 4) || (c >= 11 && c <= 14)) expv = 3'b011;
            else if (c >= 6 && c <= 9)                      expv = 3'b101;
            else                                            expv = 3'b111;
            chk($sformatf("seq_c%0d", c), {RCHAT_, RCHBT_, busy}, expv);
            @(negedge clk);
        end
        drain();

        // Single carry between RDH1 and RDH2
        mode   = 1;
        hcount = 0;
        chat   = 14'h0005;
        chbt   = 14'h1234;
        start_read(n);
        push(28'h0018000, 2'd1, 1'b0, n + 26);
        drain();
        mode = 0;

        // Exhaustion: high word changes on every strobe; hi2 sequence ends at 0x104
        mode = 2;
        chat = 14'h0100;
        chbt = 14'h0055;
        start_read(n);
        push(28'h0410055, 2'd3, 1'b1, n + 48);
        drain();
        mode = 0;

        // Reset during RDL
        chat = 14'h0AAA;
        chbt = 14'h1555;
        start_read(n);
        k = 0;
        while (RCHBT_ !== 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("reach_RDL", {31'd0, RCHBT_}, 32'd0);
        #1 rst_ = 1'b0;
        #1;
        chk("midrst_RCHBT_", RCHBT_, 1'b1);
        chk("midrst_RCHAT_", RCHAT_, 1'b1);
        chk("midrst_busy",   busy,   1'b0);
        chk("midrst_count",  count,  28'h0);
        lg    = '0;
        exp_m = 1'b0;
        @(negedge clk);
        rst_ = 1'b1;
        repeat (2) @(negedge clk);
        start_read(n);
        push(28'h2AA9555, 2'd0, 1'b0, n + 15);
        drain();

        // Second req while busy is ignored
        chat = 14'h0011;
        chbt = 14'h0022;
        start_read(n);
        push(28'h0044022, 2'd0, 1'b0, n + 15);
        repeat (4) @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        drain();
        repeat (20) @(negedge clk);

        // req held high: back-to-back reads with one IDLE cycle between them
        chat = 14'h0033;
        chbt = 14'h0044;
        @(negedge clk);
        req = 1'b1;
        n   = cyc + 1;
        push(28'h00CC044, 2'd0, 1'b0, n + 15);
        push(28'h00CC044, 2'd0, 1'b0, n + 32);
        k = 0;
        while (cyc < n + 17 && k < 100) begin
            @(negedge clk);
            k++;
        end
        req = 1'b0;
        drain();
        repeat (20) @(negedge clk);

`ifdef SCALER_READER_MONO_EN
        // Monotonic check: a drop, a recovery, and an allowed wrap
        chat = 14'h0000; chbt = 14'h0100;
        start_read(n); push(28'h0000100, 2'd0, 1'b0, n + 15); drain();
        chat = 14'h0000; chbt = 14'h00FF;
        start_read(n); push(28'h00000FF, 2'd0, 1'b0, n + 15); drain();
        chk("mono_drop", mono_err, 1'b1);
        chat = 14'h0000; chbt = 14'h0200;
        start_read(n); push(28'h0000200, 2'd0, 1'b0, n + 15); drain();
        chk("mono_recover", mono_err, 1'b0);
        chat = 14'h3FFF; chbt = 14'h3FFF;
        start_read(n); push(28'hFFFFFFF, 2'd0, 1'b0, n + 15); drain();
        chat = 14'h0000; chbt = 14'h0003;
        start_read(n); push(28'h0000003, 2'd0, 1'b0, n + 15); drain();
        chk("mono_wrap", mono_err, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scaler_channel_reader.md
# scaler_channel_reader

Bus-side reader for the scaler's two 14-bit channel ports, CHAT (high word) and CHBT (low word). On request, it drives the active-low read strobes RCHAT_ and RCHBT_ in a fixed high/low/high sequence and samples the returned words. If the scaler carried between the two high-word reads, it retries. It presents one coherent 28-bit count with a one-cycle valid pulse. It sits between the scaler (A1) and any consumer that needs an atomic time-stamp.

## Interface
Parameters:
- STROBE_CYC, 4: cycles each read strobe is held low; ≥1.
- GAP_CYC, 1: cycles with both strobes high between consecutive strobes; ≥1.
- MAX_RETRY, 3: maximum low/high re-read passes before giving up; ≥0.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_  in  1  asynchronous, active-low reset.
- req  in  1  start a read; sampled only in IDLE.
- chat  in  14  CHAT14..CHAT01 (bit 13 = CHAT14), high word.
- chbt  in  14  CHBT14..CHBT01, low word.
- RCHAT_  out  1  active-low high-word read strobe.
- RCHBT_  out  1  active-low low-word read strobe.
- busy  out  1  high from the first strobe cycle until the valid cycle inclusive.
- valid  out  1  one-cycle pulse; count/fail are meaningful.
- count  out  28  {high word, low word}; holds until the next valid.
- retries  out  2  re-read passes used by the last result; saturates at 3.
- fail  out  1  last result exhausted MAX_RETRY without two matching high words.

## Operation
- States:
  - IDLE
  - RDH1: RCHAT_ low
  - GAPA
  - RDL: RCHBT_ low
  - GAPB
  - RDH2: RCHAT_ low
  - CHECK
  - DONE
- IDLE → RDH1 when req=1. Strobe states last STROBE_CYC cycles, and gap states last GAP_CYC cycles, counted by one shared down-counter.
- Sampling happens at the clock edge ending the last cycle of each strobe state:
  - RDH1 captures hi1.
  - RDL captures lo.
  - RDH2 captures hi2.
- In CHECK:
  - If hi2 == hi1 → DONE, with count = {hi1, lo}, fail=0.
  - If hi2 != hi1 and the retry count is below MAX_RETRY → hi1 := hi2, retry count +1, then GAPA → RDL → GAPB → RDH2 → CHECK.
  - If hi2 != hi1 and retries are exhausted → DONE, with count = {hi2, lo}, fail=1.
- DONE: valid=1 for one cycle, busy=1, then IDLE. The retry counter clears on leaving IDLE.
- RCHAT_ and RCHBT_ are never low in the same cycle. Both are high in IDLE, gap, CHECK and DONE.
- A req arriving while busy is ignored and not queued. A req held high in DONE is not seen until IDLE; the next read starts one cycle after IDLE is reached.
- chat/chbt are ignored outside the sampling edges.
- Reset values: state IDLE, RCHAT_=1, RCHBT_=1, busy=0, valid=0, count=0, retries=0, fail=0.
- Reset asserted mid-operation releases both strobes immediately (asynchronously) and discards partial samples.

## Timing
- Strobe pins are registered outputs. The first RCHAT_ low cycle is the cycle after the edge that samples req=1.
- Latency with no retry, S=STROBE_CYC and G=GAP_CYC: valid is high in cycle 3S+2G+2 after the req-sampling edge. Defaults give 16.
- Each retry adds 2S+2G+1 cycles. Defaults give 11, so a single retry puts valid in cycle 27.
- With MAX_RETRY=0, the first mismatch goes straight to DONE with fail=1 at the no-retry latency.
- count, retries and fail update on the same edge valid rises, and are stable for at least one cycle after valid falls.

## Configuration
- SCALER_READER_MONO_EN defined:
  - Adds output mono_err (1 bit, reset 0) and a 28-bit last-good register (reset 0).
  - On each valid with fail=0, mono_err = (count < last-good). Wrap from 2^28−1 to a value below 2^20 is not an error.
  - last-good is updated whenever the check passes.
  - mono_err holds until the next valid.
- Not defined: no mono_err port and no last-good register. Behaviour is otherwise identical.

## Test plan
- **Clean read:** chat=14'h0123, chbt=14'h2ABC held, req pulse.
  - valid in cycle 16, count=28'h048EABC, retries=0, fail=0.
  - Strobe sequence A(4), gap(1), B(4), gap(1), A(4), with no overlap.
- **Single carry:** chat changes 14'h0005→14'h0006 between RDH1 and RDH2, chbt=0 afterwards.
  - valid in cycle 27, count={14'h0006, 14'h0000}, retries=1, fail=0.
- **Exhaustion:** chat toggles on every RCHAT_ strobe, MAX_RETRY=3.
  - fail=1, retries=3, count high word = last hi2.
  - valid in cycle 16+3·11=49.
- **Reset mid-read:** rst_ low during RDL.
  - RCHBT_=1 within the same cycle, busy=0, count=0.
  - After release, req yields a fresh correct read.
- **Req while busy:** a second req pulse in cycle 5 is ignored, giving exactly one valid. req held high continuously gives back-to-back reads, with one IDLE cycle between.
- **MONO_EN:** reads of 28'h0000100 then 28'h00000FF → mono_err=1. A following read of 28'h0000200 → mono_err=0. A read of 28'hFFFFFFF then 28'h0000003 → mono_err=0.
